hidden_layer_ctrl: RTL and testbench

Sequencer for the hidden layer of the digit-recognition network.
- On `start`, computes all NUM_HID hidden-unit activations in turn; per unit:
  - streams NUM_IN pixel/weight pairs from the input and weight RAMs through an internal multiply-accumulate;
  - maps the sum through the activation ROM;
  - writes the 8-bit result into the hidden-unit RAM at the unit's address.
- Sole driver of the hidden-unit RAM write port during the hidden-layer phase.

---
 rtl/nn_pkg.sv | 23 ++
 rtl/nn_mac.sv | 41 ++++
 rtl/hidden_layer_ctrl.sv | 144 ++++++++++++++
 tb/tb_hidden_layer_ctrl.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/nn_pkg.sv
// Shared constants and types for the digit-recognition network datapath.
package nn_pkg;

  localparam int unsigned NUM_IN     = 784;
  localparam int unsigned NUM_HID    = 32;

  localparam int unsigned IN_ADDR_W  = 10;
  localparam int unsigned WT_ADDR_W  = 15;
  localparam int unsigned HID_ADDR_W = 5;
  localparam int unsigned ACT_ADDR_W = 11;

  localparam int unsigned DATA_WIDTH = 8;
  localparam int unsigned ACC_W      = 26;

  typedef enum logic [2:0] {
    StIdle,
    StMac,
    StDrain,
    StAct,
    StWrite
  } hid_state_t;

endpackage

// File: rtl/nn_mac.sv
// Unsigned-pixel by signed-weight multiply with a signed accumulator.
module nn_mac
  import nn_pkg::*;
(
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clr,
  input  logic                         en,
  input  logic        [DATA_WIDTH-1:0] a,
  input  logic signed [DATA_WIDTH-1:0] b,
  output logic signed [ACC_W-1:0]      acc
);

  localparam int unsigned ProdW = 2 * DATA_WIDTH + 1;

  logic signed [ProdW-1:0] prod;
  logic signed [ACC_W-1:0] acc_q, acc_d;

  // Zero-extend the pixel so the product stays signed.
  assign prod = $signed({1'b0, a}) * b;

  always_comb begin
    acc_d = acc_q;
    if (clr) begin
      acc_d = '0;
    end else if (en) begin
      acc_d = acc_q + {{(ACC_W - ProdW){prod[ProdW-1]}}, prod};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc = acc_q;

endmodule

// File: rtl/hidden_layer_ctrl.sv
// Hidden-layer sequencer: MAC over all pixels per unit, activation lookup,
// and a single write of each unit's result into the hidden-unit RAM.
module hidden_layer_ctrl #(
  parameter int unsigned NUM_IN    = nn_pkg::NUM_IN,
  parameter int unsigned NUM_HID   = nn_pkg::NUM_HID,
  parameter int unsigned ACT_SHIFT = 7
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  output logic                              busy,
  output logic                              done,
  output logic [nn_pkg::IN_ADDR_W-1:0]      in_addr,
  input  logic [nn_pkg::DATA_WIDTH-1:0]     in_q,
  output logic [nn_pkg::WT_ADDR_W-1:0]      wt_addr,
  input  logic [nn_pkg::DATA_WIDTH-1:0]     wt_q,
  output logic [nn_pkg::ACT_ADDR_W-1:0]     act_addr,
  input  logic [nn_pkg::DATA_WIDTH-1:0]     act_q,
  output logic [nn_pkg::HID_ADDR_W-1:0]     hid_addr,
  output logic [nn_pkg::DATA_WIDTH-1:0]     hid_data,
  output logic                              hid_we
);

  import nn_pkg::*;

  localparam logic [IN_ADDR_W-1:0]  LastPix  = IN_ADDR_W'(NUM_IN - 1);
  localparam logic [HID_ADDR_W-1:0] LastUnit = HID_ADDR_W'(NUM_HID - 1);

  hid_state_t state_q, state_d;

  logic [IN_ADDR_W-1:0]  pix_cnt_q, pix_cnt_d;
  logic [WT_ADDR_W-1:0]  wt_cnt_q, wt_cnt_d;
  logic [HID_ADDR_W-1:0] unit_q, unit_d;
  logic                  valid_q;
  logic                  done_q, done_d;
  logic                  acc_clr;

  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] shifted;
  logic signed [10:0]      sat;

  always_comb begin
    state_d   = state_q;
    pix_cnt_d = pix_cnt_q;
    wt_cnt_d  = wt_cnt_q;
    unit_d    = unit_q;
    done_d    = 1'b0;
    acc_clr   = 1'b0;

    case (state_q)
      StIdle: begin
        // The done cycle is itself IDLE; refusing start there forces a gap.
        if (start && !done_q) begin
          state_d   = StMac;
          pix_cnt_d = '0;
          wt_cnt_d  = '0;
          unit_d    = '0;
          acc_clr   = 1'b1;
        end
      end
      StMac: begin
        pix_cnt_d = pix_cnt_q + 1'b1;
        wt_cnt_d  = wt_cnt_q + 1'b1;
        if (pix_cnt_q == LastPix) begin
          pix_cnt_d = '0;
          state_d   = StDrain;
        end
      end
      StDrain: begin
        state_d = StAct;
      end
      StAct: begin
        state_d = StWrite;
      end
      StWrite: begin
        acc_clr = 1'b1;
        if (unit_q == LastUnit) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end else begin
          unit_d    = unit_q + 1'b1;
          pix_cnt_d = '0;
          state_d   = StMac;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      pix_cnt_q <= '0;
      wt_cnt_q  <= '0;
      unit_q    <= '0;
      valid_q   <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pix_cnt_q <= pix_cnt_d;
      wt_cnt_q  <= wt_cnt_d;
      unit_q    <= unit_d;
      // RAM data lags the address by one cycle.
      valid_q   <= (state_q == StMac);
      done_q    <= done_d;
    end
  end

  nn_mac u_mac (
    .clk (clk),
    .rst (rst),
    .clr (acc_clr),
    .en  (valid_q),
    .a   (in_q),
    .b   (wt_q),
    .acc (acc)
  );

  assign shifted = acc >>> ACT_SHIFT;

  always_comb begin
    if (shifted > 26'sd1023) begin
      sat = 11'sh3ff;
    end else if (shifted < -26'sd1024) begin
      sat = 11'sh400;
    end else begin
      sat = shifted[10:0];
    end
  end

  // Adding 1024 to an 11-bit signed value is an MSB flip.
  assign act_addr = (state_q == StAct) ? {~sat[10], sat[9:0]} : '0;

  assign busy     = (state_q != StIdle);
  assign done     = done_q;
  assign in_addr  = pix_cnt_q;
  assign wt_addr  = wt_cnt_q;
  assign hid_addr = unit_q;
  assign hid_we   = (state_q == StWrite);
  assign hid_data = hid_we ? act_q : '0;

endmodule

// File: tb/tb_hidden_layer_ctrl.sv
// Directed bench for hidden_layer_ctrl with behavioural RAM/ROM models.
module tb_hidden_layer_ctrl;

  localparam int UnitCyc = 787;
  localparam int LastWr  = 25184;
  localparam int DoneCyc = 25185;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        busy, done, hid_we;
  logic [9:0]  in_addr;
  logic [7:0]  in_q;
  logic [14:0] wt_addr;
  logic [7:0]  wt_q;
  logic [10:0] act_addr;
  logic [7:0]  act_q;
  logic [4:0]  hid_addr;
  logic [7:0]  hid_data;

  int checks = 0;
  int errors = 0;

  int mode = 0;
  logic [7:0] pix_val = 8'd1;
  logic clr_mem = 1'b0;
  logic [7:0] hid_mem [32];
  logic [7:0] snap [32];
  logic [10:0] act_seen [32];
  int wr_total = 0;
  int done_total = 0;

  int bad_addr, bad_we, bad_busy, bad_done, bad_mem;
  int wr0, dn0;

  always #5 clk = ~clk;

  hidden_layer_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .busy     (busy),
    .done     (done),
    .in_addr  (in_addr),
    .in_q     (in_q),
    .wt_addr  (wt_addr),
    .wt_q     (wt_q),
    .act_addr (act_addr),
    .act_q    (act_q),
    .hid_addr (hid_addr),
    .hid_data (hid_data),
    .hid_we   (hid_we)
  );

  // Pixel RAM, weight RAM and activation ROM, each with one cycle of latency.
  always @(posedge clk) begin
    in_q  <= pix_val;
    act_q <= act_addr[10:3];
    case (mode)
      0:       wt_q <= 8'd1;
      1:       wt_q <= 8'(int'(wt_addr) / 784);
      default: wt_q <= ((int'(wt_addr) / 784) % 2 == 0) ? 8'd127 : 8'h80;
    endcase
  end

  always @(posedge clk) begin
    if (clr_mem) begin
      for (int i = 0; i < 32; i++) hid_mem[i] <= 8'hee;
    end else if (hid_we) begin
      hid_mem[hid_addr] <= hid_data;
      wr_total <= wr_total + 1;
    end
    if (done) done_total <= done_total + 1;
  end

  function automatic int exp_hid(input int u);
    case (mode)
      0:       return 128;
      1:       return (1024 + ((784 * u) >> 7)) >> 3;
      default: return (u % 2 == 0) ? 255 : 0;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Walks cycles 1..last_k after start acceptance, checking against the schedule.
  task automatic run_pass(input int last_k, input int pulse_k, input int rst_k, input bit hold);
    int u, p;
    bad_addr = 0; bad_we = 0; bad_busy = 0; bad_done = 0;
    for (int k = 1; k <= last_k; k++) begin
      @(negedge clk);
      u = (k - 1) / UnitCyc;
      p = (k - 1) % UnitCyc;
      if (k <= LastWr && p < 784) begin
        if (in_addr !== 10'(p) || wt_addr !== 15'(u * 784 + p)) bad_addr++;
      end
      if (k <= LastWr && p == 785) act_seen[u] = act_addr;
      if (k <= LastWr && p == 786) begin
        if (hid_we !== 1'b1 || hid_addr !== 5'(u) || hid_data !== 8'(exp_hid(u))) bad_we++;
      end else if (hid_we !== 1'b0) begin
        bad_we++;
      end
      if (busy !== (k <= LastWr)) bad_busy++;
      if (done !== (k == DoneCyc)) bad_done++;
      start = hold || (k == pulse_k);
      if (k == rst_k) rst = 1'b1;
    end
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_we", hid_we, 0);
    chk("rst_in_addr", in_addr, 0);
    chk("rst_wt_addr", wt_addr, 0);
    chk("rst_act_addr", act_addr, 0);
    chk("rst_hid_addr", hid_addr, 0);
    rst = 1'b0;
    @(negedge clk);

    // Pass A: unit pixels and weights, stray start pulse during unit 5.
    mode = 0; pix_val = 8'd1;
    wr0 = wr_total; dn0 = done_total;
    start = 1'b1;
    run_pass(DoneCyc, 5 * UnitCyc + 10, -1, 1'b0);
    chk("a_addr_seq", bad_addr, 0);
    chk("a_write", bad_we, 0);
    chk("a_busy", bad_busy, 0);
    chk("a_done_timing", bad_done, 0);
    chk("a_act_u0", act_seen[0], 1030);
    chk("a_act_u31", act_seen[31], 1030);
    @(negedge clk);
    chk("a_writes", wr_total - wr0, 32);
    chk("a_dones", done_total - dn0, 1);
    bad_mem = 0;
    for (int i = 0; i < 32; i++) if (hid_mem[i] !== 8'd128) bad_mem++;
    chk("a_mem", bad_mem, 0);

    // Pass B: weight = unit index, reset during unit 10 MAC.
    mode = 1;
    clr_mem = 1'b1;
    @(negedge clk);
    clr_mem = 1'b0;
    wr0 = wr_total; dn0 = done_total;
    start = 1'b1;
    run_pass(10 * UnitCyc + 101, -1, 10 * UnitCyc + 101, 1'b0);
    chk("b_addr_seq", bad_addr, 0);
    chk("b_write", bad_we, 0);
    chk("b_act_u3", act_seen[3], 1042);
    @(negedge clk);
    chk("b_rst_busy", busy, 0);
    chk("b_rst_we", hid_we, 0);
    chk("b_rst_done", done, 0);
    chk("b_rst_in_addr", in_addr, 0);
    chk("b_rst_wt_addr", wt_addr, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("b_idle_busy", busy, 0);
    chk("b_writes", wr_total - wr0, 10);
    chk("b_dones", done_total - dn0, 0);
    chk("b_mem0", hid_mem[0], 128);
    chk("b_mem9", hid_mem[9], 134);
    bad_mem = 0;
    for (int i = 1; i < 9; i++) if (hid_mem[i] !== 8'(exp_hid(i))) bad_mem++;
    chk("b_mem_written", bad_mem, 0);
    bad_mem = 0;
    for (int i = 10; i < 32; i++) if (hid_mem[i] !== 8'hee) bad_mem++;
    chk("b_mem_untouched", bad_mem, 0);

    // Passes C and D: saturating weights, start held high throughout.
    mode = 2; pix_val = 8'd255;
    wr0 = wr_total; dn0 = done_total;
    start = 1'b1;
    run_pass(DoneCyc, -1, -1, 1'b1);
    chk("c_addr_seq", bad_addr, 0);
    chk("c_write", bad_we, 0);
    chk("c_busy", bad_busy, 0);
    chk("c_done_timing", bad_done, 0);
    chk("c_act_pos_sat", act_seen[0], 2047);
    chk("c_act_neg_sat", act_seen[1], 0);
    for (int i = 0; i < 32; i++) snap[i] = hid_mem[i];
    @(negedge clk);
    chk("c_gap_busy", busy, 0);
    chk("c_gap_done", done, 0);
    chk("c_mem_u0", snap[0], 255);
    chk("c_mem_u1", snap[1], 0);
    run_pass(DoneCyc, -1, -1, 1'b1);
    start = 1'b0;
    chk("d_addr_seq", bad_addr, 0);
    chk("d_write", bad_we, 0);
    chk("d_busy", bad_busy, 0);
    chk("d_done_timing", bad_done, 0);
    @(negedge clk);
    chk("d_idle_busy", busy, 0);
    chk("cd_writes", wr_total - wr0, 64);
    chk("cd_dones", done_total - dn0, 2);
    bad_mem = 0;
    for (int i = 0; i < 32; i++) begin
      if (hid_mem[i] !== snap[i] || hid_mem[i] !== 8'(exp_hid(i))) bad_mem++;
    end
    chk("cd_mem_repeat", bad_mem, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
